// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and constants for the memory controller.
// Contents:
//   mem_state_e   - controller FSM states (IDLE / READ / WRITE)
//   owner_e       - which requester owns the current transaction
//   MEM_SIZE_*    - LSU access size encodings
//   size_to_bytes - LSU size code to byte count (code 3 behaves as a word)
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE  = 2'd0,
        MEM_STATE_READ  = 2'd1,
        MEM_STATE_WRITE = 2'd2
    } mem_state_e;

    typedef enum logic {
        OWNER_IFETCH = 1'b0,
        OWNER_LSU    = 1'b1
    } owner_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: return 3'd1;
            MEM_SIZE_HALF: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
// Bundles the core-side request/response signals and the 8-bit RAM bus of
// the memory controller.
//   master : the environment (fetch unit, LSU, ROB, RAM, UART status)
//   slave  : the controller itself
// Signals:
//   ifetch_enable_in/addr_in, ifetch_done_out/data_out   fetch port
//   lsu_enable_in/rw_flag_in/size_in/addr_in/data_in,
//   lsu_done_out/data_out                                 load/store port
//   roll_back_flag_from_rob                               pipeline flush
//   mem_din, mem_dout, mem_a, mem_wr                      RAM bus
//   io_buffer_full                                        UART buffer full
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                ifetch_enable_in;
    logic [ADDR_W-1:0]   ifetch_addr_in;
    logic                ifetch_done_out;
    logic [DATA_W-1:0]   ifetch_data_out;

    logic                lsu_enable_in;
    logic                lsu_rw_flag_in;
    logic [1:0]          lsu_size_in;
    logic [ADDR_W-1:0]   lsu_addr_in;
    logic [DATA_W-1:0]   lsu_data_in;
    logic                lsu_done_out;
    logic [DATA_W-1:0]   lsu_data_out;

    logic                roll_back_flag_from_rob;

    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;
    logic [ADDR_W-1:0]   mem_a;
    logic                mem_wr;
    logic                io_buffer_full;

    modport master (
        output ifetch_enable_in, ifetch_addr_in,
        input  ifetch_done_out, ifetch_data_out,
        output lsu_enable_in, lsu_rw_flag_in, lsu_size_in, lsu_addr_in, lsu_data_in,
        input  lsu_done_out, lsu_data_out,
        output roll_back_flag_from_rob,
        output mem_din,
        input  mem_dout, mem_a, mem_wr,
        output io_buffer_full
    );

    modport slave (
        input  ifetch_enable_in, ifetch_addr_in,
        output ifetch_done_out, ifetch_data_out,
        input  lsu_enable_in, lsu_rw_flag_in, lsu_size_in, lsu_addr_in, lsu_data_in,
        output lsu_done_out, lsu_data_out,
        input  roll_back_flag_from_rob,
        input  mem_din,
        output mem_dout, mem_a, mem_wr,
        input  io_buffer_full
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Arbitrates instruction fetch and the LSU onto a single-port 8-bit RAM,
// serialising each request into byte transfers and reassembling read data
// little-endian. Reads can be aborted by a rollback; writes always finish.
// Ports:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - global ready; low freezes every register
//   bus     - mem_ctrl_if.slave (fetch port, LSU port, rollback, RAM bus)
// Build option:
//   IO_BUFFER_STALL_EN - when defined, writes to the IO page
//                        (address bits [17:16] == 2'b11) wait while
//                        io_buffer_full is high; otherwise it is ignored.
//
// state           | meaning
// MEM_STATE_IDLE  | bus parked (mem_a = 0, mem_wr = 0), arbitrating
// MEM_STATE_READ  | issuing addresses / capturing mem_din for a read
// MEM_STATE_WRITE | issuing byte writes for an LSU store
//
// stage counts bytes already placed on the bus. The grant edge puts byte 0
// on the bus, so a transaction of n bytes finishes n edges after the grant.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    mem_state_e  state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic [2:0]  nbytes_q, nbytes_d;
    owner_e      owner_q, owner_d;
    owner_e      last_grant_q, last_grant_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        ifetch_done_q, ifetch_done_d;
    logic [31:0] ifetch_data_q, ifetch_data_d;
    logic        lsu_done_q, lsu_done_d;
    logic [31:0] lsu_data_q, lsu_data_d;

    logic io_full;
`ifdef IO_BUFFER_STALL_EN
    assign io_full = bus.io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = bus.io_buffer_full;
    assign io_full        = 1'b0;
`endif

    // Arbitration: on a tie the requester not granted last wins.
    logic        pick_lsu;
    logic        g_read;
    logic [31:0] g_addr;
    logic [2:0]  g_n;
    logic        g_stall;

    assign pick_lsu = bus.lsu_enable_in &
                      (~bus.ifetch_enable_in | (last_grant_q == OWNER_IFETCH));
    assign g_read   = pick_lsu ? bus.lsu_rw_flag_in : 1'b1;
    assign g_addr   = pick_lsu ? bus.lsu_addr_in : bus.ifetch_addr_in;
    assign g_n      = pick_lsu ? size_to_bytes(bus.lsu_size_in) : 3'd4;
    assign g_stall  = io_full & (g_addr[17:16] == 2'b11);

    logic [31:0] issue_addr;
    logic [31:0] wshift;
    logic [1:0]  rd_idx;
    logic [31:0] rd_word;
    logic        w_stall;

    assign issue_addr = base_q + {29'd0, stage_q};
    assign wshift     = wdata_q >> {stage_q, 3'b000};
    assign w_stall    = io_full & (issue_addr[17:16] == 2'b11);
    // mem_din belongs to the address on the bus now, i.e. byte stage-1.
    assign rd_idx     = stage_q[1:0] - 2'd1;
    assign rd_word    = rbuf_q | ({24'd0, bus.mem_din} << {rd_idx, 3'b000});

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        nbytes_d      = nbytes_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        rbuf_d        = rbuf_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = 1'b0;
        ifetch_done_d = 1'b0;
        ifetch_data_d = ifetch_data_q;
        lsu_done_d    = 1'b0;
        lsu_data_d    = lsu_data_q;

        case (state_q)
            MEM_STATE_IDLE: begin
                mem_a_d = '0;
                if (!bus.roll_back_flag_from_rob && !ifetch_done_q && !lsu_done_q &&
                    (bus.ifetch_enable_in || bus.lsu_enable_in)) begin
                    owner_d      = pick_lsu ? OWNER_LSU : OWNER_IFETCH;
                    last_grant_d = pick_lsu ? OWNER_LSU : OWNER_IFETCH;
                    base_d       = g_addr;
                    nbytes_d     = g_n;
                    wdata_d      = bus.lsu_data_in;
                    rbuf_d       = '0;
                    mem_a_d      = g_addr;
                    stage_d      = 3'd1;
                    if (g_read) begin
                        state_d = MEM_STATE_READ;
                    end else begin
                        state_d    = MEM_STATE_WRITE;
                        mem_dout_d = bus.lsu_data_in[7:0];
                        if (g_stall) begin
                            stage_d = 3'd0;
                        end else begin
                            mem_wr_d = 1'b1;
                        end
                    end
                end
            end

            MEM_STATE_READ: begin
                if (bus.roll_back_flag_from_rob) begin
                    state_d = MEM_STATE_IDLE;
                    stage_d = 3'd0;
                    mem_a_d = '0;
                end else begin
                    rbuf_d = rd_word;
                    if (stage_q < nbytes_q) begin
                        mem_a_d = issue_addr;
                        stage_d = stage_q + 3'd1;
                    end else begin
                        state_d = MEM_STATE_IDLE;
                        stage_d = 3'd0;
                        mem_a_d = '0;
                        if (owner_q == OWNER_IFETCH) begin
                            ifetch_done_d = 1'b1;
                            ifetch_data_d = rd_word;
                        end else begin
                            lsu_done_d = 1'b1;
                            lsu_data_d = rd_word;
                        end
                    end
                end
            end

            MEM_STATE_WRITE: begin
                if (stage_q < nbytes_q) begin
                    mem_a_d    = issue_addr;
                    mem_dout_d = wshift[7:0];
                    if (!w_stall) begin
                        mem_wr_d = 1'b1;
                        stage_d  = stage_q + 3'd1;
                    end
                end else begin
                    state_d    = MEM_STATE_IDLE;
                    stage_d    = 3'd0;
                    mem_a_d    = '0;
                    lsu_done_d = 1'b1;
                end
            end

            default: begin
                state_d = MEM_STATE_IDLE;
                stage_d = 3'd0;
                mem_a_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= MEM_STATE_IDLE;
            stage_q       <= 3'd0;
            nbytes_q      <= 3'd0;
            owner_q       <= OWNER_IFETCH;
            last_grant_q  <= OWNER_IFETCH;
            base_q        <= '0;
            wdata_q       <= '0;
            rbuf_q        <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
            ifetch_done_q <= 1'b0;
            ifetch_data_q <= '0;
            lsu_done_q    <= 1'b0;
            lsu_data_q    <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            nbytes_q      <= nbytes_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            rbuf_q        <= rbuf_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            ifetch_done_q <= ifetch_done_d;
            ifetch_data_q <= ifetch_data_d;
            lsu_done_q    <= lsu_done_d;
            lsu_data_q    <= lsu_data_d;
        end
    end

    assign bus.mem_a           = mem_a_q;
    assign bus.mem_dout        = mem_dout_q;
    assign bus.mem_wr          = mem_wr_q;
    assign bus.ifetch_done_out = ifetch_done_q;
    assign bus.ifetch_data_out = ifetch_data_q;
    assign bus.lsu_done_out    = lsu_done_q;
    assign bus.lsu_data_out    = lsu_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Directed bench for mem_ctrl: a vector table of single transactions plus
// hand-written sequences for arbitration ties, rollback, rdy stalls and the
// IO-page write stall (IO_BUFFER_STALL_EN selects the expected behaviour).
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    // RAM model: asynchronous read of the registered address, 64 KiB window.
    logic [7:0] ram [0:65535];
    assign bus.mem_din = ram[bus.mem_a[15:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
            ram[16'h1000] <= 8'h11;
            ram[16'h1001] <= 8'h22;
            ram[16'h1002] <= 8'h33;
            ram[16'h1003] <= 8'h44;
            ram[16'h0400] <= 8'hA1;
            ram[16'h0401] <= 8'hB2;
            ram[16'h0402] <= 8'hC3;
            ram[16'h0403] <= 8'hD4;
            ram[16'hFFFF] <= 8'h77;
            ram[16'h0000] <= 8'h01;
            ram[16'h0001] <= 8'h02;
            ram[16'h0002] <= 8'h03;
        end else if (rdy && bus.mem_wr) begin
            ram[bus.mem_a[15:0]] <= bus.mem_dout;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lsu_req(input logic rd, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
        bus.lsu_enable_in  = 1'b1;
        bus.lsu_rw_flag_in = rd;
        bus.lsu_size_in    = size;
        bus.lsu_addr_in    = addr;
        bus.lsu_data_in    = data;
    endtask

    task automatic wait_done(input bit fetch, input int maxc);
        int c;
        c = 0;
        while (c < maxc && !(fetch ? bus.ifetch_done_out : bus.lsu_done_out)) begin
            step();
            c++;
        end
        check(fetch ? "fetch done seen" : "lsu done seen",
              32'(fetch ? bus.ifetch_done_out : bus.lsu_done_out), 32'd1);
    endtask

    typedef struct {
        string       name;
        bit          fetch;
        logic        rd;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input vec_t v);
        logic [31:0] wexp;
        bus.ifetch_enable_in = v.fetch;
        bus.ifetch_addr_in   = v.addr;
        if (!v.fetch) lsu_req(v.rd, v.size, v.addr, v.wdata);
        for (int k = 1; k <= v.n; k++) begin
            step();
            check({v.name, " mem_a"}, bus.mem_a, v.addr + 32'(k - 1));
            check({v.name, " mem_wr"}, 32'(bus.mem_wr), 32'(!v.rd));
            if (!v.rd) begin
                wexp = v.wdata >> (8 * (k - 1));
                check({v.name, " mem_dout"}, 32'(bus.mem_dout), {24'd0, wexp[7:0]});
            end
            check({v.name, " early done"}, 32'(bus.ifetch_done_out | bus.lsu_done_out), 32'd0);
        end
        step();
        check({v.name, " fetch done"}, 32'(bus.ifetch_done_out), 32'(v.fetch));
        check({v.name, " lsu done"}, 32'(bus.lsu_done_out), 32'(!v.fetch));
        if (v.rd)
            check({v.name, " data"}, v.fetch ? bus.ifetch_data_out : bus.lsu_data_out, v.exp);
        check({v.name, " idle mem_wr"}, 32'(bus.mem_wr), 32'd0);
        check({v.name, " idle mem_a"}, bus.mem_a, 32'd0);
        bus.ifetch_enable_in = 1'b0;
        bus.lsu_enable_in    = 1'b0;
        step();
        check({v.name, " done drop"}, 32'(bus.ifetch_done_out | bus.lsu_done_out), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"fetch 1000",  1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h0,           4, 32'h4433_2211};
        vecs[1]  = '{"sh 200",      1'b0, 1'b0, 2'd1, 32'h0000_0200, 32'hDEAD_BEEF,   2, 32'h0};
        vecs[2]  = '{"lw 200",      1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'h0,           4, 32'h0000_BEEF};
        vecs[3]  = '{"lb 403",      1'b0, 1'b1, 2'd0, 32'h0000_0403, 32'h0,           1, 32'h0000_00D4};
        vecs[4]  = '{"lh 402",      1'b0, 1'b1, 2'd1, 32'h0000_0402, 32'h0,           2, 32'h0000_D4C3};
        vecs[5]  = '{"lsize3 400",  1'b0, 1'b1, 2'd3, 32'h0000_0400, 32'h0,           4, 32'hD4C3_B2A1};
        vecs[6]  = '{"sb 404",      1'b0, 1'b0, 2'd0, 32'h0000_0404, 32'h1234_56AB,   1, 32'h0};
        vecs[7]  = '{"sw 7fc",      1'b0, 1'b0, 2'd2, 32'h0000_07FC, 32'hCAFE_F00D,   4, 32'h0};
        vecs[8]  = '{"fetch 7fc",   1'b1, 1'b1, 2'd2, 32'h0000_07FC, 32'h0,           4, 32'hCAFE_F00D};
        vecs[9]  = '{"fetch wrap",  1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0,           4, 32'h0302_0177};
        vecs[10] = '{"lb 404",      1'b0, 1'b1, 2'd0, 32'h0000_0404, 32'h0,           1, 32'h0000_00AB};

        rst = 1'b1;
        rdy = 1'b1;
        bus.ifetch_enable_in        = 1'b0;
        bus.ifetch_addr_in          = '0;
        bus.lsu_enable_in           = 1'b0;
        bus.lsu_rw_flag_in          = 1'b0;
        bus.lsu_size_in             = '0;
        bus.lsu_addr_in             = '0;
        bus.lsu_data_in             = '0;
        bus.roll_back_flag_from_rob = 1'b0;
        bus.io_buffer_full          = 1'b0;

        step();
        step();
        check("rst mem_a", bus.mem_a, 32'd0);
        check("rst mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst done", 32'(bus.ifetch_done_out | bus.lsu_done_out), 32'd0);
        check("rst ifetch_data", bus.ifetch_data_out, 32'd0);
        check("rst lsu_data", bus.lsu_data_out, 32'd0);
        rst = 1'b0;

        // Tie straight out of reset: LSU first, then fetch; ties then alternate.
        bus.ifetch_enable_in = 1'b1;
        bus.ifetch_addr_in   = 32'h0000_1000;
        lsu_req(1'b1, MEM_SIZE_BYTE, 32'h0000_0403, 32'h0);
        step();
        check("tie1 lsu first", bus.mem_a, 32'h0000_0403);
        step();
        check("tie1 lsu done", 32'(bus.lsu_done_out), 32'd1);
        check("tie1 lsu data", bus.lsu_data_out, 32'h0000_00D4);
        check("tie1 no fetch done", 32'(bus.ifetch_done_out), 32'd0);
        bus.lsu_enable_in = 1'b0;
        step();
        check("tie1 no grant in done", bus.mem_a, 32'd0);
        step();
        check("tie1 fetch second", bus.mem_a, 32'h0000_1000);
        wait_done(1'b1, 6);
        check("tie1 fetch data", bus.ifetch_data_out, 32'h4433_2211);
        lsu_req(1'b1, MEM_SIZE_BYTE, 32'h0000_0403, 32'h0);
        step();
        check("tie2 idle", bus.mem_a, 32'd0);
        step();
        check("tie2 lsu wins", bus.mem_a, 32'h0000_0403);
        step();
        check("tie2 lsu done", 32'(bus.lsu_done_out), 32'd1);
        step();
        step();
        check("tie3 fetch wins", bus.mem_a, 32'h0000_1000);
        bus.lsu_enable_in = 1'b0;
        wait_done(1'b1, 6);
        check("tie3 fetch data", bus.ifetch_data_out, 32'h4433_2211);
        bus.ifetch_enable_in = 1'b0;
        step();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Rollback during a fetch at stage 2; pending LSU is granted next.
        bus.ifetch_enable_in = 1'b1;
        bus.ifetch_addr_in   = 32'h0000_1000;
        step();
        check("rb fetch a0", bus.mem_a, 32'h0000_1000);
        lsu_req(1'b1, MEM_SIZE_BYTE, 32'h0000_0404, 32'h0);
        step();
        check("rb fetch a1", bus.mem_a, 32'h0000_1001);
        bus.roll_back_flag_from_rob = 1'b1;
        step();
        check("rb idle mem_a", bus.mem_a, 32'd0);
        check("rb idle mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rb no fetch done", 32'(bus.ifetch_done_out), 32'd0);
        bus.roll_back_flag_from_rob = 1'b0;
        bus.ifetch_enable_in        = 1'b0;
        step();
        check("rb lsu granted", bus.mem_a, 32'h0000_0404);
        check("rb no fetch done 2", 32'(bus.ifetch_done_out), 32'd0);
        step();
        check("rb lsu done", 32'(bus.lsu_done_out), 32'd1);
        check("rb lsu data", bus.lsu_data_out, 32'h0000_00AB);
        bus.lsu_enable_in = 1'b0;
        step();

        // Rollback during a word store: all four bytes still go out.
        lsu_req(1'b0, MEM_SIZE_WORD, 32'h0000_0500, 32'h0102_0304);
        step();
        check("rb sw b0", {bus.mem_a[23:0], bus.mem_dout}, {24'h000500, 8'h04});
        step();
        check("rb sw b1", {bus.mem_a[23:0], bus.mem_dout}, {24'h000501, 8'h03});
        bus.roll_back_flag_from_rob = 1'b1;
        step();
        check("rb sw b2", {bus.mem_a[23:0], bus.mem_dout}, {24'h000502, 8'h02});
        check("rb sw wr2", 32'(bus.mem_wr), 32'd1);
        step();
        check("rb sw b3", {bus.mem_a[23:0], bus.mem_dout}, {24'h000503, 8'h01});
        check("rb sw wr3", 32'(bus.mem_wr), 32'd1);
        step();
        check("rb sw done", 32'(bus.lsu_done_out), 32'd1);
        check("rb sw wr off", 32'(bus.mem_wr), 32'd0);
        bus.lsu_enable_in    = 1'b0;
        bus.ifetch_enable_in = 1'b1;
        bus.ifetch_addr_in   = 32'h0000_1000;
        step();
        step();
        check("rb blocks grant", bus.mem_a, 32'd0);
        bus.roll_back_flag_from_rob = 1'b0;
        step();
        check("grant after rb", bus.mem_a, 32'h0000_1000);
        wait_done(1'b1, 6);
        check("fetch after rb data", bus.ifetch_data_out, 32'h4433_2211);
        bus.ifetch_enable_in = 1'b0;
        step();

        // rdy low for two cycles in the middle of a word load.
        lsu_req(1'b1, MEM_SIZE_WORD, 32'h0000_0400, 32'h0);
        step();
        check("rdy a0", bus.mem_a, 32'h0000_0400);
        step();
        check("rdy a1", bus.mem_a, 32'h0000_0401);
        rdy = 1'b0;
        step();
        check("rdy frozen 1", bus.mem_a, 32'h0000_0401);
        step();
        check("rdy frozen 2", bus.mem_a, 32'h0000_0401);
        check("rdy no done", 32'(bus.lsu_done_out), 32'd0);
        rdy = 1'b1;
        step();
        check("rdy a2", bus.mem_a, 32'h0000_0402);
        step();
        check("rdy a3", bus.mem_a, 32'h0000_0403);
        check("rdy not yet done", 32'(bus.lsu_done_out), 32'd0);
        step();
        check("rdy done delayed", 32'(bus.lsu_done_out), 32'd1);
        check("rdy data", bus.lsu_data_out, 32'hD4C3_B2A1);
        bus.lsu_enable_in = 1'b0;
        step();

        // Non-IO address never stalls, even with the buffer full.
        bus.io_buffer_full = 1'b1;
        lsu_req(1'b0, MEM_SIZE_BYTE, 32'h0002_0000, 32'h0000_0077);
        step();
        check("nonio wr", 32'(bus.mem_wr), 32'd1);
        check("nonio dout", 32'(bus.mem_dout), 32'h77);
        step();
        check("nonio done", 32'(bus.lsu_done_out), 32'd1);
        bus.lsu_enable_in = 1'b0;
        step();

        // IO page store with the buffer full for three edges.
        lsu_req(1'b0, MEM_SIZE_BYTE, 32'h0003_0000, 32'h0000_005A);
`ifdef IO_BUFFER_STALL_EN
        step();
        check("io stall wr c1", 32'(bus.mem_wr), 32'd0);
        step();
        check("io stall wr c2", 32'(bus.mem_wr), 32'd0);
        step();
        check("io stall wr c3", 32'(bus.mem_wr), 32'd0);
        check("io stall no done", 32'(bus.lsu_done_out), 32'd0);
        bus.io_buffer_full = 1'b0;
        step();
        check("io write wr", 32'(bus.mem_wr), 32'd1);
        check("io write a", bus.mem_a, 32'h0003_0000);
        check("io write dout", 32'(bus.mem_dout), 32'h5A);
        step();
        check("io done", 32'(bus.lsu_done_out), 32'd1);
        check("io wr off", 32'(bus.mem_wr), 32'd0);
`else
        step();
        check("io ignored wr", 32'(bus.mem_wr), 32'd1);
        check("io ignored a", bus.mem_a, 32'h0003_0000);
        check("io ignored dout", 32'(bus.mem_dout), 32'h5A);
        bus.io_buffer_full = 1'b0;
        step();
        check("io ignored done", 32'(bus.lsu_done_out), 32'd1);
        check("io ignored wr off", 32'(bus.mem_wr), 32'd0);
`endif
        bus.lsu_enable_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
